// File: rtl/regfile_bypass_sb_pkg.sv
// Shared core constants: default widths, the hardwired-zero register index
// and which writeback port wins when both target the same register.
package regfile_bypass_sb_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;

  typedef enum logic {
    WR_PORT0 = 1'b0,
    WR_PORT1 = 1'b1
  } wr_port_e;

  // The LSU port is the later producer in program order on a collision.
  localparam wr_port_e WR_PRIO_PORT = WR_PORT1;

endpackage

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register busy scoreboard: flush > issue > writeback, plus busy lookup
// for both read ports (optionally masked by a same-cycle writeback).
module regfile_bypass_sb_scoreboard
  import regfile_bypass_sb_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_addr,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_en && iss_rd == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  function automatic logic lookup(input logic [AW-1:0]    addr,
                                  input logic [NREGS-1:0] state,
                                  input logic             w0_en,
                                  input logic [AW-1:0]    w0_addr,
                                  input logic             w1_en,
                                  input logic [AW-1:0]    w1_addr);
    logic wr_hit;
    wr_hit = (w0_en && w0_addr == addr) || (w1_en && w1_addr == addr);
    if (addr == AW'(REG_ZERO)) begin
      return 1'b0;
    end
    // A writeback landing this cycle resolves the hazard when forwarding is on.
    return state[addr] && !((BYPASS != 0) && wr_hit);
  endfunction

  assign rs1_busy = lookup(rs1_addr, busy_q, wr0_en, wr0_addr, wr1_en, wr1_addr);
  assign rs2_busy = lookup(rs2_addr, busy_q, wr0_en, wr0_addr, wr1_en, wr1_addr);
  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Two-write-port integer register file with optional write-to-read bypass
// and an issue-stage busy scoreboard. x0 reads as zero and is never busy.
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_addr,
  input  logic [XLEN-1:0]  wr0_data,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  input  logic [XLEN-1:0]  wr1_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];

  logic            hi_en;
  logic            lo_en;
  logic [AW-1:0]   hi_addr;
  logic [AW-1:0]   lo_addr;
  logic [XLEN-1:0] hi_data;
  logic [XLEN-1:0] lo_data;

  // Order the two write ports so storage and bypass share one priority.
  always_comb begin
    if (WR_PRIO_PORT == WR_PORT1) begin
      hi_en = wr1_en; hi_addr = wr1_addr; hi_data = wr1_data;
      lo_en = wr0_en; lo_addr = wr0_addr; lo_data = wr0_data;
    end else begin
      hi_en = wr0_en; hi_addr = wr0_addr; hi_data = wr0_data;
      lo_en = wr1_en; lo_addr = wr1_addr; lo_data = wr1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (hi_en && hi_addr == AW'(r)) begin
          regs_q[r] <= hi_data;
        end else if (lo_en && lo_addr == AW'(r)) begin
          regs_q[r] <= lo_data;
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] read_sel(input logic            rst_ok,
                                               input logic [AW-1:0]   addr,
                                               input logic [XLEN-1:0] stored,
                                               input logic            h_en,
                                               input logic [AW-1:0]   h_addr,
                                               input logic [XLEN-1:0] h_data,
                                               input logic            l_en,
                                               input logic [AW-1:0]   l_addr,
                                               input logic [XLEN-1:0] l_data);
    if (!rst_ok || addr == AW'(REG_ZERO)) begin
      return '0;
    end
    if ((BYPASS != 0) && h_en && h_addr == addr) begin
      return h_data;
    end
    if ((BYPASS != 0) && l_en && l_addr == addr) begin
      return l_data;
    end
    return stored;
  endfunction

  assign rs1_data = read_sel(rst_n, rs1_addr, regs_q[rs1_addr],
                             hi_en, hi_addr, hi_data, lo_en, lo_addr, lo_data);
  assign rs2_data = read_sel(rst_n, rs2_addr, regs_q[rs2_addr],
                             hi_en, hi_addr, hi_data, lo_en, lo_addr, lo_data);

  regfile_bypass_sb_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .flush    (flush),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench: bypassing and non-bypassing 32x32 instances share stimulus;
// a 64-bit, 16-register bypassing instance repeats the key cases.
module tb_regfile_bypass_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the 32-bit instances.
  logic [4:0]  rs1_addr, rs2_addr, wr0_addr, wr1_addr, iss_rd;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_en, wr1_en, iss_en, flush;
  logic [31:0] b1_rs1_data, b1_rs2_data, b0_rs1_data, b0_rs2_data;
  logic        b1_rs1_busy, b1_rs2_busy, b0_rs1_busy, b0_rs2_busy;
  logic [31:0] b1_busy_vec, b0_busy_vec;

  // Wide instance stimulus.
  logic [3:0]  w_rs1_addr, w_rs2_addr, w_wr0_addr, w_wr1_addr, w_iss_rd;
  logic [63:0] w_wr0_data, w_wr1_data;
  logic        w_wr0_en, w_wr1_en, w_iss_en, w_flush;
  logic [63:0] w_rs1_data, w_rs2_data;
  logic        w_rs1_busy, w_rs2_busy;
  logic [15:0] w_busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_bypass_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b1_rs1_data), .rs2_data(b1_rs2_data),
    .rs1_busy(b1_rs1_busy), .rs2_busy(b1_rs2_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_vec(b1_busy_vec)
  );

  regfile_bypass_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data),
    .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .busy_vec(b0_busy_vec)
  );

  regfile_bypass_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
    .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
    .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
    .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
    .wr1_en(w_wr1_en), .wr1_addr(w_wr1_addr), .wr1_data(w_wr1_data),
    .iss_en(w_iss_en), .iss_rd(w_iss_rd), .flush(w_flush),
    .busy_vec(w_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
    w_wr0_en = 0; w_wr1_en = 0; w_iss_en = 0; w_flush = 0;
  endtask

  initial begin
    rst_n = 0;
    rs1_addr = 5; rs2_addr = 0; wr0_addr = 0; wr1_addr = 0; iss_rd = 0;
    wr0_data = 0; wr1_data = 0;
    w_rs1_addr = 0; w_rs2_addr = 0; w_wr0_addr = 0; w_wr1_addr = 0; w_iss_rd = 0;
    w_wr0_data = 0; w_wr1_data = 0;
    idle();

    // Reset: a write presented during reset must neither show nor stick.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
    #2;
    chk("rst_rs1_b1", b1_rs1_data, 0);
    chk("rst_rs1_b0", b0_rs1_data, 0);
    chk("rst_busy_b1", b1_busy_vec, 0);
    chk("rst_busy_w", w_busy_vec, 0);
    tick();
    idle();
    #1;
    chk("rst_nowrite_b1", b1_rs1_data, 0);
    rst_n = 1;

    // Write x5 after reset release.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
    #1;
    chk("x5_byp_b1", b1_rs1_data, 32'hDEAD_BEEF);
    chk("x5_byp_b0", b0_rs1_data, 0);
    tick(); idle(); #1;
    chk("x5_read_b1", b1_rs1_data, 32'hDEAD_BEEF);
    chk("x5_read_b0", b0_rs1_data, 32'hDEAD_BEEF);

    // Dual-write collision on x7: port 1 wins.
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2222;
    rs1_addr = 7;
    #1;
    chk("coll_byp_b1", b1_rs1_data, 32'h2222);
    chk("coll_byp_b0", b0_rs1_data, 0);
    tick(); idle(); #1;
    chk("coll_read_b1", b1_rs1_data, 32'h2222);
    chk("coll_read_b0", b0_rs1_data, 32'h2222);

    // Bypass versus stored value on read port 2.
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5A5;
    rs2_addr = 3;
    #1;
    chk("byp_rs2_b1", b1_rs2_data, 32'hA5A5);
    chk("byp_rs2_b0", b0_rs2_data, 0);
    tick(); idle(); #1;
    chk("next_rs2_b0", b0_rs2_data, 32'hA5A5);

    // Scoreboard lifecycle on x9.
    iss_en = 1; iss_rd = 9;
    tick(); idle();
    rs1_addr = 9;
    #1;
    chk("iss9_vec_b1", b1_busy_vec[9], 1);
    chk("iss9_rs1busy_b0", b0_rs1_busy, 1);
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h9999;
    #1;
    chk("wb9_rs1busy_b1", b1_rs1_busy, 0);
    chk("wb9_rs1busy_b0", b0_rs1_busy, 1);
    tick(); idle(); #1;
    chk("wb9_vec_b1", b1_busy_vec, 0);
    chk("wb9_vec_b0", b0_busy_vec, 0);

    // Issue beats a same-cycle writeback to x4; re-issue keeps it busy.
    iss_en = 1; iss_rd = 4;
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h4444;
    tick(); idle(); #1;
    chk("iss_wb4_vec", b1_busy_vec, 32'h0000_0010);
    iss_en = 1; iss_rd = 4;
    tick(); idle(); #1;
    chk("reiss4_vec", b1_busy_vec, 32'h0000_0010);

    // Flush overrides issue of x6; the x6 data write still lands.
    flush = 1; iss_en = 1; iss_rd = 6;
    wr1_en = 1; wr1_addr = 6; wr1_data = 32'h6666;
    tick(); idle();
    rs1_addr = 6;
    #1;
    chk("flush_vec_b1", b1_busy_vec, 0);
    chk("flush_vec_b0", b0_busy_vec, 0);
    chk("flush_x6_b0", b0_rs1_data, 32'h6666);

    // x0 stays zero and never busy.
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF;
    iss_en = 1; iss_rd = 0; rs1_addr = 0;
    #1;
    chk("x0_byp_b1", b1_rs1_data, 0);
    tick(); idle(); #1;
    chk("x0_read_b1", b1_rs1_data, 0);
    chk("x0_vec_b1", b1_busy_vec, 0);
    chk("x0_rs1busy_b1", b1_rs1_busy, 0);

    // Wide instance: XLEN=64, NREGS=16.
    w_wr0_en = 1; w_wr0_addr = 5; w_wr0_data = 64'hDEAD_BEEF_CAFE_F00D;
    w_rs1_addr = 5;
    #1;
    chk("w_x5_byp", w_rs1_data, 64'hDEAD_BEEF_CAFE_F00D);
    tick(); idle(); #1;
    chk("w_x5_read", w_rs1_data, 64'hDEAD_BEEF_CAFE_F00D);

    w_wr0_en = 1; w_wr0_addr = 7; w_wr0_data = 64'h1111_0000_0000_1111;
    w_wr1_en = 1; w_wr1_addr = 7; w_wr1_data = 64'h2222_0000_0000_2222;
    w_rs1_addr = 7;
    #1;
    chk("w_coll_byp", w_rs1_data, 64'h2222_0000_0000_2222);
    tick(); idle(); #1;
    chk("w_coll_read", w_rs1_data, 64'h2222_0000_0000_2222);

    w_wr1_en = 1; w_wr1_addr = 15; w_wr1_data = 64'hF0F0_F0F0_0F0F_0F0F;
    tick(); idle();
    w_rs2_addr = 15;
    #1;
    chk("w_x15_read", w_rs2_data, 64'hF0F0_F0F0_0F0F_0F0F);

    w_iss_en = 1; w_iss_rd = 9;
    tick(); idle();
    w_rs1_addr = 9;
    #1;
    chk("w_iss9_vec", w_busy_vec, 16'h0200);
    w_wr1_en = 1; w_wr1_addr = 9; w_wr1_data = 64'h9;
    #1;
    chk("w_wb9_rs1busy", w_rs1_busy, 0);
    tick(); idle(); #1;
    chk("w_wb9_vec", w_busy_vec, 0);

    w_iss_en = 1; w_iss_rd = 4;
    w_wr0_en = 1; w_wr0_addr = 4; w_wr0_data = 64'h4;
    tick(); idle(); #1;
    chk("w_iss_wb4_vec", w_busy_vec, 16'h0010);
    w_flush = 1; w_iss_en = 1; w_iss_rd = 6;
    w_wr0_en = 1; w_wr0_addr = 6; w_wr0_data = 64'h6666_0000_0000_6666;
    tick(); idle();
    w_rs2_addr = 6;
    #1;
    chk("w_flush_vec", w_busy_vec, 0);
    chk("w_flush_x6", w_rs2_data, 64'h6666_0000_0000_6666);

    w_wr0_en = 1; w_wr0_addr = 0; w_wr0_data = '1;
    w_iss_en = 1; w_iss_rd = 0; w_rs1_addr = 0;
    tick(); idle(); #1;
    chk("w_x0_read", w_rs1_data, 0);
    chk("w_x0_vec", w_busy_vec, 0);

    // Asynchronous reset mid-operation clears state without a clock edge.
    #2;
    rst_n = 0;
    #1;
    rs1_addr = 6;
    #1;
    chk("async_rst_x6", b0_rs1_data, 0);
    rst_n = 1;
    iss_en = 1; iss_rd = 2;
    tick(); idle(); #1;
    chk("post_rst_iss2", b1_busy_vec, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor of the core integer register file, generalised in data width and register count.
- Adds a second write port, optional write-to-read bypass, and a per-register busy scoreboard for the issue stage.
- Sits between decode/issue (read ports, issue marking) and the two writeback paths (ALU and load/store).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, at least 2; index 0 is hardwired zero
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
AW, $clog2(NREGS), localparam address width; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data, combinational
rs2_data  output  XLEN  read port 2 data, combinational
rs1_busy  output  1  read port 1 register awaiting writeback
rs2_busy  output  1  read port 2 register awaiting writeback
wr0_en  input  1  write port 0 enable (ALU writeback)
wr0_addr  input  AW  write port 0 address
wr0_data  input  XLEN  write port 0 data
wr1_en  input  1  write port 1 enable (LSU writeback)
wr1_addr  input  AW  write port 1 address
wr1_data  input  XLEN  write port 1 data
iss_en  input  1  issue strobe: mark iss_rd busy
iss_rd  input  AW  destination register of the issuing instruction
flush  input  1  clear every busy bit (pipeline flush)
busy_vec  output  NREGS  registered scoreboard state; bit 0 always 0

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, all registers are 0 and busy_vec=0. rsN_data=0 and rsN_busy=0 for any address.
- Storage write: at posedge clk, if wrK_en=1 and wrK_addr!=0, the register takes wrK_data. If both ports target the same nonzero address, port 1 wins. Writes to address 0 are discarded.
- Read: zero latency, combinational.
  - Address 0 returns 0 and busy 0.
  - BYPASS=1: if an enabled write this cycle targets rsN_addr (nonzero), rsN_data is that write's data, with port 1 priority; otherwise the stored value.
  - BYPASS=0: always the stored value; new data is visible the cycle after the write.
- Scoreboard, per register r != 0, evaluated at each posedge:
  - Next state priority is flush > issue > writeback.
  - flush=1: busy cleared for all r; iss_en is ignored that cycle. Register data writes still occur.
  - Otherwise, iss_en=1 and iss_rd==r: busy[r] set. This wins over a same-cycle writeback to r, since the newer producer owns r.
  - Otherwise, an enabled write to r clears busy[r].
  - Otherwise busy[r] holds.
- rsN_busy:
  - BYPASS=1: busy[rsN_addr] AND NOT (an enabled write to rsN_addr this cycle).
  - BYPASS=0: busy[rsN_addr].
  - Always 0 for address 0.
- Re-issue of an already busy register: it stays busy. No counting; one outstanding producer per register is assumed by the issue logic.
- Reset mid-operation: state clears immediately and asynchronously. The first edge after rst_n rises behaves as a normal cycle.

Decomposition:
- The shared core package holds XLEN_DEFAULT, NREGS_DEFAULT, the REG_ZERO constant and the write-port priority constant (port 1 > port 0). The pipeline and this block both use them.
- One sub-module is natural: regfile_scoreboard. It contains the busy_vec state, flush/issue/clear priority, and busy lookup. The data array and bypass muxing stay in the parent.

Test Plan:
- Reset then read: rst_n=0 with rs1_addr=5 -> rs1_data=0, busy_vec=0. After writing x5=32'hDEAD_BEEF and deasserting rst_n, reading x5 returns that value.
- Dual-write collision: wr0 x7=32'h1111 and wr1 x7=32'h2222 in the same cycle -> next cycle rs1_addr=7 gives 32'h2222. Same-cycle read with BYPASS=1 also gives 32'h2222.
- Bypass vs no bypass: write x3=32'hA5A5 while rs2_addr=3. BYPASS=1 gives 32'hA5A5 in the same cycle; BYPASS=0 gives the old 0, then 32'hA5A5 next cycle.
- Scoreboard lifecycle: iss_en with iss_rd=9 -> busy_vec[9]=1 next cycle. wr1 x9 then gives rs1_busy=0 in that cycle (BYPASS=1) and busy_vec[9]=0 next cycle.
- Issue/write/flush collisions:
  - iss_rd=4 issued and wr0 x4 in the same cycle -> busy_vec[4]=1.
  - flush with iss_en iss_rd=6 -> busy_vec all 0, and the x6 write data from the same cycle is still stored.
- x0 and width sweep: write x0=32'hFFFF and issue iss_rd=0 -> rs1_data=0, busy_vec[0]=0. Repeat directed cases at XLEN=64, NREGS=16.
